riscv_mem_arbiter: RTL and testbench
====================================

RISCV_MEM_ARBITER -- requirements
Module: riscv_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, byte address width of all address ports.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, width of all data ports.
REQ-003 SHALL have parameter MAX_WAIT, default 4, consecutive denied fetch cycles before fetch is forced to win.
REQ-004 SHALL have ports: clk  in  1  sole clock, rising edge; reset  in  1  asynchronous, active-high.
REQ-005 SHALL have fetch ports: if_req_valid in 1; if_req_ready out 1; if_addr in ADDR_WIDTH; if_rsp_valid out 1; if_rdata out DATA_WIDTH.
REQ-006 SHALL have data ports: d_req_valid in 1; d_req_ready out 1; d_we in 1 (1 = store); d_addr in ADDR_WIDTH; d_wdata in DATA_WIDTH; d_rsp_valid out 1; d_rdata out DATA_WIDTH.
REQ-007 SHALL have memory ports: mem_en out 1; mem_we out 1; mem_addr out ADDR_WIDTH; mem_wdata out DATA_WIDTH; mem_rdata in DATA_WIDTH (synchronous read, valid the cycle after mem_en).

Function
REQ-008 SHALL share one single-port memory between fetch and data requesters, at most one access per cycle.
REQ-009 SHALL treat a request as accepted in a cycle where its valid and ready are both high; ready SHALL be combinational, never depending on that requester's own valid.
REQ-010 SHALL grant data when only d_req_valid is high and fetch when only if_req_valid is high.
REQ-011 SHALL, when both valid, grant data unless starve_cnt equals MAX_WAIT, in which case fetch is granted.
REQ-012 SHALL increment starve_cnt (saturating at MAX_WAIT) each cycle if_req_valid is high and fetch is not granted; SHALL clear it when fetch is granted or if_req_valid is low.
REQ-013 SHALL drive mem_en = 1 in the grant cycle, with mem_addr/mem_we/mem_wdata taken combinationally from the granted requester; fetch grant drives mem_we = 0.
REQ-014 SHALL register the owner of each granted read (FETCH, DATA, NONE) for exactly one cycle to route the response.
REQ-015 SHALL assert if_rsp_valid for one cycle, exactly one cycle after an accepted fetch, with if_rdata = mem_rdata.
REQ-016 SHALL assert d_rsp_valid for one cycle, exactly one cycle after an accepted load (d_we = 0); stores SHALL produce no response.
REQ-017 SHALL drive if_rdata/d_rdata to zero whenever the corresponding rsp_valid is low.
REQ-018 SHALL sustain back-to-back accepts (one per cycle), with each response overlapping the next grant.
REQ-019 SHALL, with no valid request, hold mem_en = 0, mem_we = 0, and both readys high.
REQ-020 SHALL ignore address and data inputs of a requester whose valid is low.

Reset
REQ-021 SHALL, while reset is high, force starve_cnt = 0, owner = NONE, if_rsp_valid = 0, d_rsp_valid = 0, mem_en = 0, mem_we = 0, both readys = 0.
REQ-022 SHALL discard any response owed at reset assertion; no rsp_valid pulse after reset release without a new accept.
REQ-023 SHALL accept requests in the first rising edge after reset deasserts.

Structure
REQ-024 SHALL place the owner enumeration (NONE, FETCH, DATA) in the shared riscv_defines package.
REQ-025 SHALL be a single module with no sub-modules; arbitration and starvation counter are inline.

Verification
REQ-026 Fetch only, if_addr=0x10, mem_rdata=0x00A00093 -> mem_en=1, mem_addr=0x10 cycle N; if_rsp_valid=1, if_rdata=0x00A00093 cycle N+1.
REQ-027 Both valid, d_we=1, d_addr=0x4, d_wdata=0x15 -> d_req_ready=1, if_req_ready=0, mem_we=1, mem_wdata=0x15; no response pulse N+1.
REQ-028 Both held valid 6 cycles (loads) -> data granted cycles 0-3, fetch granted cycle 4, starve_cnt returns to 0 cycle 5.
REQ-029 Alternating fetch 0x0/load 0x8 every cycle -> mem_en continuously high, responses routed to the correct port one cycle later, none lost.
REQ-030 Load accepted cycle N, reset asserted cycle N+1 asynchronously -> d_rsp_valid stays 0; all outputs at REQ-021 values.
REQ-031 Idle 10 cycles after reset -> mem_en=0, both readys=1, no rsp_valid pulses.

Source files
------------

// File: rtl/riscv_defines.sv
// Shared definitions for the RISC-V memory subsystem: response-owner encoding
// and a helper to size saturating counters.
package riscv_defines;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_DATA  = 2'd2
  } owner_e;

  // Bits needed to hold 0..max_val inclusive (at least one).
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/riscv_mem_arbiter.sv
// Fetch/data arbiter in front of one single-port synchronous-read memory.
// Data wins contention unless fetch has been denied MAX_WAIT cycles in a row.
module riscv_mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_WAIT   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_req_valid,
  output logic                  if_req_ready,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_rsp_valid,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic                  d_req_valid,
  output logic                  d_req_ready,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_rsp_valid,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  import riscv_defines::*;

  localparam int              CNT_W   = cnt_width(MAX_WAIT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] starve_q, starve_d;
  owner_e           owner_q, owner_d;
  logic             starved;
  logic             gnt_if;
  logic             gnt_d;

  // Readies depend only on the other requester and the counter, never on own valid.
  always_comb begin
    starved      = (starve_q == CNT_MAX);
    if_req_ready = !reset && (!d_req_valid || starved);
    d_req_ready  = !reset && !(if_req_valid && starved);
    gnt_if       = if_req_valid && if_req_ready;
    gnt_d        = d_req_valid && d_req_ready;
  end

  always_comb begin
    starve_d = starve_q;
    owner_d  = OWN_NONE;
    if (!if_req_valid || gnt_if) begin
      starve_d = '0;
    end else if (!starved) begin
      starve_d = starve_q + CNT_W'(1);
    end
    if (gnt_if) begin
      owner_d = OWN_FETCH;
    end else if (gnt_d && !d_we) begin
      owner_d = OWN_DATA;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_q <= '0;
      owner_q  <= OWN_NONE;
    end else begin
      starve_q <= starve_d;
      owner_q  <= owner_d;
    end
  end

  // Memory port is steered from the winner; a losing or idle requester contributes nothing.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt_if) begin
      mem_en   = 1'b1;
      mem_addr = if_addr;
    end else if (gnt_d) begin
      mem_en    = 1'b1;
      mem_we    = d_we;
      mem_addr  = d_addr;
      mem_wdata = d_we ? d_wdata : '0;
    end
  end

  always_comb begin
    if_rsp_valid = (owner_q == OWN_FETCH);
    d_rsp_valid  = (owner_q == OWN_DATA);
    if_rdata     = if_rsp_valid ? mem_rdata : '0;
    d_rdata      = d_rsp_valid ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Randomized bench for riscv_mem_arbiter against a transaction-level model
// with a shadow memory, plus directed scenarios for the key corner cases.
module tb_riscv_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req_valid, if_req_ready, if_rsp_valid;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          d_req_valid, d_req_ready, d_we, d_rsp_valid;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  riscv_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WAIT(MW)) dut (
    .clk(clk), .reset(reset),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
    .if_rsp_valid(if_rsp_valid), .if_rdata(if_rdata),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_we(d_we),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_rsp_valid(d_rsp_valid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input int idx);
    return (idx * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  // Environment memory: 256 words, synchronous read.
  logic [31:0] mem [0:255];
  bit          mem_wr [0:255];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        mem[mem_addr[9:2]]    <= mem_wdata;
        mem_wr[mem_addr[9:2]] <= 1'b1;
      end else begin
        mem_rdata <= mem_wr[mem_addr[9:2]] ? mem[mem_addr[9:2]] : init_val(int'(mem_addr[9:2]));
      end
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model state
  logic [31:0] shadow [0:255];
  int          m_starve;
  bit          p_if, p_d;
  logic [31:0] p_data;

  logic          obs_if_rdy, obs_d_rdy, obs_en, obs_we, obs_if_rv, obs_d_rv;
  logic [AW-1:0] obs_addr;
  logic [DW-1:0] obs_wdata, obs_if_rd;

  task automatic model_check();
    bit fw, dw;
    obs_if_rdy = if_req_ready; obs_d_rdy = d_req_ready; obs_en = mem_en;
    obs_we = mem_we; obs_addr = mem_addr; obs_wdata = mem_wdata;
    obs_if_rv = if_rsp_valid; obs_d_rv = d_rsp_valid; obs_if_rd = if_rdata;
    if (reset) begin
      check_eq("rst_if_ready", if_req_ready, 0);
      check_eq("rst_d_ready", d_req_ready, 0);
      check_eq("rst_mem_en", mem_en, 0);
      check_eq("rst_mem_we", mem_we, 0);
      check_eq("rst_if_rsp", if_rsp_valid, 0);
      check_eq("rst_d_rsp", d_rsp_valid, 0);
      m_starve = 0; p_if = 0; p_d = 0;
      return;
    end
    fw = if_req_valid && (!d_req_valid || m_starve == MW);
    dw = d_req_valid && !fw;
    check_eq("if_ready", if_req_ready, !d_req_valid || m_starve == MW);
    check_eq("d_ready", d_req_ready, !(if_req_valid && m_starve == MW));
    check_eq("mem_en", mem_en, fw || dw);
    check_eq("mem_we", mem_we, dw && d_we);
    if (fw) check_eq("mem_addr_f", mem_addr, if_addr);
    if (dw) check_eq("mem_addr_d", mem_addr, d_addr);
    if (dw && d_we) check_eq("mem_wdata", mem_wdata, d_wdata);
    check_eq("if_rsp_valid", if_rsp_valid, p_if);
    check_eq("d_rsp_valid", d_rsp_valid, p_d);
    check_eq("if_rdata", if_rdata, p_if ? p_data : 32'h0);
    check_eq("d_rdata", d_rdata, p_d ? p_data : 32'h0);
    // Advance model
    if (if_req_valid && !fw) m_starve = (m_starve < MW) ? m_starve + 1 : MW;
    else                     m_starve = 0;
    p_if = fw;
    p_d  = dw && !d_we;
    if (fw)            p_data = shadow[if_addr[9:2]];
    else if (dw && !d_we) p_data = shadow[d_addr[9:2]];
    if (dw && d_we) shadow[d_addr[9:2]] = d_wdata;
  endtask

  task automatic drive(input logic ifv, input logic [31:0] ia, input logic dv,
                       input logic we, input logic [31:0] da, input logic [31:0] wd);
    if_req_valid = ifv; if_addr = ia;
    d_req_valid = dv; d_we = we; d_addr = da; d_wdata = wd;
  endtask

  task automatic do_cycle(input logic ifv, input logic [31:0] ia, input logic dv,
                          input logic we, input logic [31:0] da, input logic [31:0] wd);
    drive(ifv, ia, dv, we, da, wd);
    @(negedge clk);
    model_check();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    do_cycle(0, $urandom, 0, $urandom_range(0, 1), $urandom, $urandom);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) shadow[i] = init_val(i);
    m_starve = 0; p_if = 0; p_d = 0; p_data = '0;
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) do_cycle(1, 32'h10, 1, 0, 32'h20, 0);
    reset = 1'b0;

    // Idle after reset: readys high, no memory activity, no responses
    repeat (10) idle();
    check_eq("idle_if_ready", obs_if_rdy, 1);
    check_eq("idle_d_ready", obs_d_rdy, 1);

    // Store the instruction word, then fetch it
    do_cycle(0, 0, 1, 1, 32'h10, 32'h00A00093);
    do_cycle(1, 32'h10, 0, 0, $urandom, $urandom);
    check_eq("fetch_mem_en", obs_en, 1);
    check_eq("fetch_mem_addr", obs_addr, 32'h10);
    do_cycle(0, 0, 0, 0, 0, 0);
    check_eq("fetch_rsp_valid", obs_if_rv, 1);
    check_eq("fetch_rdata", obs_if_rd, 32'h00A00093);

    // Contention with a store: data wins, store yields no response
    do_cycle(1, 32'h40, 1, 1, 32'h4, 32'h15);
    check_eq("st_d_ready", obs_d_rdy, 1);
    check_eq("st_if_ready", obs_if_rdy, 0);
    check_eq("st_mem_we", obs_we, 1);
    check_eq("st_mem_wdata", obs_wdata, 32'h15);
    idle();
    check_eq("st_no_d_rsp", obs_d_rv, 0);
    check_eq("st_no_if_rsp", obs_if_rv, 0);

    // Sustained contention: fetch forced through on the fifth cycle
    idle();
    for (int i = 0; i < 6; i++) begin
      do_cycle(1, 32'h80, 1, 0, 32'hC, 0);
      check_eq($sformatf("starve_if_grant%0d", i), obs_if_rdy, (i == 4));
    end
    idle();

    // Alternating fetch/load every cycle: memory never idle
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) do_cycle(1, 32'h0, 0, 0, 0, 0);
      else            do_cycle(0, 0, 1, 0, 32'h8, 0);
      check_eq("alt_mem_en", obs_en, 1);
    end
    idle();

    // Asynchronous reset right after a load is accepted discards its response
    do_cycle(0, 0, 1, 0, 32'h8, 0);
    drive(0, 0, 0, 0, 0, 0);
    #1 reset = 1'b1;
    @(negedge clk);
    model_check();
    @(posedge clk);
    #1;
    do_cycle(0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    repeat (3) idle();
    check_eq("post_rst_d_rsp", obs_d_rv, 0);
    // First edge after release accepts
    do_cycle(1, 32'h24, 0, 0, 0, 0);
    check_eq("post_rst_accept", obs_en, 1);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      do_cycle($urandom_range(0, 3) != 0, {22'h0, 8'($urandom), 2'b00},
               $urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0,
               {22'h0, 8'($urandom_range(0, 15)), 2'b00}, $urandom);
    end
    repeat (2) idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
